// File: rtl/input_bin_slice_fifo.sv
// ============================================================================
// input_bin_slice_fifo
//
// Per-unit input bin. Each accepted STREAM_WIDTH-wide sorted block carries
// a slice descriptor (first lane, length). This unit copies its slice into a
// circular buffer and drains the buffer one element per cycle to the
// downstream merge unit over a valid/ready handshake.
//
// Optional feature macro: INPUT_BIN_OVF_CHECK_EN
//   defined   : err_ovf is a sticky flag. It is raised by a block that is
//               dropped because the buffer is full, or by a slice that runs
//               past the last lane.
//   undefined : err_ovf is tied to 0 and no checking logic is built.
// ============================================================================
module input_bin_slice_fifo #(
  parameter int DATA_WIDTH       = 16,
  parameter int STREAM_WIDTH     = 8,
  parameter int LOG_STREAM_WIDTH = 3,
  parameter int DEPTH            = 4 * STREAM_WIDTH,
  parameter int LOG_DEPTH        = $clog2(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst_b,
  input  logic                                   enable,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [STREAM_WIDTH-1:0][DATA_WIDTH-1:0] din,
  input  logic [LOG_STREAM_WIDTH-1:0]            set_rd_ctr,
  input  logic [LOG_STREAM_WIDTH:0]              set_track_ctr,
  output logic [DATA_WIDTH-1:0]                  dout,
  output logic                                   dout_valid,
  input  logic                                   dout_ready,
  output logic [LOG_DEPTH:0]                     occupancy,
  output logic                                   err_ovf
);

  // Slice-length width (0..STREAM_WIDTH) and occupancy width (0..DEPTH).
  localparam int CW = LOG_STREAM_WIDTH + 1;
  localparam int OW = LOG_DEPTH + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [LOG_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Handshake and slice decode
  // --------------------------------------------------------------------------
  logic [CW-1:0] lanes_avail;
  logic [CW-1:0] eff_len;
  logic          accept;
  logic          pop;

  // Clip the slice to the lanes that exist and derive the handshake strobes.
  // NOTE: every signal gets a default at the top of always_comb. A path that
  // leaves a signal unassigned would infer a latch.
  always_comb begin
    lanes_avail = CW'(STREAM_WIDTH) - {1'b0, set_rd_ctr};
    eff_len     = (set_track_ctr < lanes_avail) ? set_track_ctr : lanes_avail;
    // Room for a whole block is required, whatever the slice length is.
    in_ready    = (occ_q <= OW'(DEPTH - STREAM_WIDTH));
    dout_valid  = (occ_q != '0);
    accept      = enable & in_valid & in_ready;
    pop         = enable & dout_valid & dout_ready;
  end

  // Compute the next pointers and occupancy. A write and a pop in the same
  // cycle are both applied.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + LOG_DEPTH'(eff_len);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
    end
    occ_d = occ_q + (accept ? OW'(eff_len) : OW'(0)) - (pop ? OW'(1) : OW'(0));
  end

  // Register the pointers and occupancy. Reset takes priority over enable.
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples values from before the clock edge, whatever order the
  // blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Copy the slice lanes into consecutive entries. The modulo-DEPTH pointer
  // arithmetic splits a slice that crosses the end of the array.
  // NOTE: the storage array has no reset. Data becomes visible only through
  // occupancy, and occupancy is reset, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (rst_b && accept) begin
      for (int k = 0; k < STREAM_WIDTH; k++) begin
        if (CW'(k) < eff_len) begin
          mem_q[wr_ptr_q + LOG_DEPTH'(k)] <= din[set_rd_ctr + LOG_STREAM_WIDTH'(k)];
        end
      end
    end
  end

  // Present the head element, forced to zero while the buffer is empty.
  always_comb begin
    dout      = dout_valid ? mem_q[rd_ptr_q] : '0;
    occupancy = occ_q;
  end

  // --------------------------------------------------------------------------
  // Optional overflow / slice-range checker
  // --------------------------------------------------------------------------
`ifdef INPUT_BIN_OVF_CHECK_EN
  localparam int SW = CW + 1;

  logic          err_q;
  logic [SW-1:0] slice_end;

  // Compute one past the last requested lane, without truncation.
  always_comb begin
    slice_end = {2'b00, set_rd_ctr} + {1'b0, set_track_ctr};
  end

  // Latch a dropped block or an out-of-range slice until reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      err_q <= 1'b0;
    end else if (enable && in_valid && (!in_ready || (slice_end > SW'(STREAM_WIDTH)))) begin
      err_q <= 1'b1;
    end
  end

  assign err_ovf = err_q;
`else
  assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_input_bin_slice_fifo.sv
// ============================================================================
// tb_input_bin_slice_fifo
//
// Self-checking bench for input_bin_slice_fifo (STREAM_WIDTH=8, DEPTH=32).
// It combines a directed vector table, hand-written wrap and streaming
// sequences, and randomized traffic. The reference is a queue of the
// elements that have been stored but not yet popped.
// ============================================================================
module tb_input_bin_slice_fifo;

  localparam int DW    = 16;
  localparam int SW    = 8;
  localparam int LSW   = 3;
  localparam int DEPTH = 32;
  localparam int LD    = 5;

`ifdef INPUT_BIN_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_b;
  logic                  enable;
  logic                  in_valid;
  logic                  in_ready;
  logic [SW-1:0][DW-1:0] din;
  logic [LSW-1:0]        set_rd_ctr;
  logic [LSW:0]          set_track_ctr;
  logic [DW-1:0]         dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [LD:0]           occupancy;
  logic                  err_ovf;

  input_bin_slice_fifo #(
    .DATA_WIDTH(DW), .STREAM_WIDTH(SW), .LOG_STREAM_WIDTH(LSW), .DEPTH(DEPTH), .LOG_DEPTH(LD)
  ) dut (
    .clk(clk), .rst_b(rst_b), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .set_rd_ctr(set_rd_ctr), .set_track_ctr(set_track_ctr),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .occupancy(occupancy), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the stored elements in pop order, plus the sticky error.
  int unsigned model_q[$];
  bit          model_err;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and check
  // the outputs 1 ns after the edge.
  task automatic step(input bit rst, input bit en, input bit vld, input int rd, input int tr,
                      input bit rdy, input logic [SW-1:0][DW-1:0] d, input string tag);
    int sz, eff;
    bit ready_m, acc, pp;
    rst_b         = !rst;
    enable        = en;
    in_valid      = vld;
    set_rd_ctr    = LSW'(rd);
    set_track_ctr = (LSW+1)'(tr);
    dout_ready    = rdy;
    din           = d;
    sz      = model_q.size();
    ready_m = (DEPTH - sz) >= SW;
    eff     = (tr < SW - rd) ? tr : SW - rd;
    acc     = en && vld && ready_m;
    pp      = en && (sz > 0) && rdy;
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      model_err = 1'b0;
    end else begin
      if (pp) void'(model_q.pop_front());
      if (acc) for (int k = 0; k < eff; k++) model_q.push_back(int'(d[rd + k]));
      if (OVF_EN && en && vld && (!ready_m || (rd + tr > SW))) model_err = 1'b1;
    end
    check({tag, ".occ"},   occupancy,  model_q.size());
    check({tag, ".dv"},    dout_valid, model_q.size() != 0);
    check({tag, ".dout"},  dout,       (model_q.size() != 0) ? model_q[0] : 0);
    check({tag, ".ready"}, in_ready,   (DEPTH - model_q.size()) >= SW);
    check({tag, ".err"},   err_ovf,    model_err);
  endtask

  function automatic logic [SW-1:0][DW-1:0] ramp(input int base);
    logic [SW-1:0][DW-1:0] r;
    for (int i = 0; i < SW; i++) r[i] = DW'(base + i);
    return r;
  endfunction

  typedef struct {
    bit rst; bit en; bit vld; int rd; int tr; bit rdy; int base;
    int occ; bit dv; int dout; bit ready; bit err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_b = 1'b0; enable = 1'b0; in_valid = 1'b0; din = '0;
    set_rd_ctr = '0; set_track_ctr = '0; dout_ready = 1'b0;
    model_err = 1'b0;

    // Fields: rst en vld rd tr rdy base | occ dv dout ready err
    vecs.push_back('{1,1,0,0,0,0,'h00,  0,0,'h00,1,0});     // reset
    vecs.push_back('{0,1,1,2,3,0,'h10,  3,1,'h12,1,0});     // lanes 2..4
    vecs.push_back('{0,1,0,0,0,1,'h00,  2,1,'h13,1,0});
    vecs.push_back('{0,1,0,0,0,1,'h00,  1,1,'h14,1,0});
    vecs.push_back('{0,1,0,0,0,1,'h00,  0,0,'h00,1,0});     // drained
    vecs.push_back('{0,1,1,0,8,0,'h20,  8,1,'h20,1,0});
    vecs.push_back('{0,1,1,0,8,0,'h30, 16,1,'h20,1,0});
    vecs.push_back('{0,1,1,0,8,0,'h40, 24,1,'h20,1,0});
    vecs.push_back('{0,1,1,0,8,0,'h50, 32,1,'h20,0,0});     // full
    vecs.push_back('{0,1,1,0,8,0,'h60, 32,1,'h20,0,OVF_EN}); // dropped
    vecs.push_back('{1,1,0,0,0,0,'h00,  0,0,'h00,1,0});     // reset
    vecs.push_back('{0,1,1,6,5,0,'h70,  2,1,'h76,1,OVF_EN}); // clipped
    vecs.push_back('{0,1,1,0,0,0,'h00,  2,1,'h76,1,OVF_EN}); // empty slice
    vecs.push_back('{0,1,1,5,2,0,'h80,  4,1,'h76,1,OVF_EN});
    vecs.push_back('{0,1,0,0,0,1,'h00,  3,1,'h77,1,OVF_EN});
    vecs.push_back('{0,0,1,0,8,1,'h90,  3,1,'h77,1,OVF_EN}); // enable low
    vecs.push_back('{0,0,1,0,8,1,'h90,  3,1,'h77,1,OVF_EN});
    vecs.push_back('{0,0,1,0,8,1,'h90,  3,1,'h77,1,OVF_EN});
    vecs.push_back('{1,1,1,0,8,1,'hA0,  0,0,'h00,1,0});     // reset mid-stream

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].rd, vecs[i].tr, vecs[i].rdy,
           ramp(vecs[i].base), t);
      check({t, ".tbl_occ"},   occupancy,  vecs[i].occ);
      check({t, ".tbl_dv"},    dout_valid, vecs[i].dv);
      check({t, ".tbl_dout"},  dout,       vecs[i].dout);
      check({t, ".tbl_ready"}, in_ready,   vecs[i].ready);
      check({t, ".tbl_err"},   err_ovf,    vecs[i].err);
    end

    // Wrap: fill to 30, drain 30, then write 8 across entries 30,31,0..5.
    step(1, 1, 0, 0, 0, 0, '0, "wrap_rst");
    for (int b = 0; b < 3; b++) step(0, 1, 1, 0, 8, 0, ramp('h100 + 16*b), "wrap_fill");
    step(0, 1, 1, 0, 6, 0, ramp('h140), "wrap_fill");
    check("wrap.occ30", occupancy, 30);
    for (int p = 0; p < 30; p++) step(0, 1, 0, 0, 0, 1, '0, "wrap_drain");
    check("wrap.empty", dout_valid, 0);
    step(0, 1, 1, 0, 8, 0, ramp('hB0), "wrap_wr");
    for (int p = 0; p < 8; p++) begin
      check($sformatf("wrap.pop%0d", p), dout, 'hB0 + p);
      step(0, 1, 0, 0, 0, 1, '0, "wrap_pop");
    end
    check("wrap.done", occupancy, 0);

    // Streaming: one element in and one out every cycle.
    for (int i = 0; i < 100; i++) begin
      logic [SW-1:0][DW-1:0] d;
      for (int l = 0; l < SW; l++) d[l] = DW'($urandom);
      step(0, 1, 1, i % SW, 1, 1, d, "stream");
      check($sformatf("stream%0d.occ1", i), occupancy, 1);
    end

    // Randomized traffic, with an occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic [SW-1:0][DW-1:0] d;
      for (int l = 0; l < SW; l++) d[l] = DW'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, SW-1), $urandom_range(0, SW), $urandom_range(0, 3) != 0, d,
           $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
